// File: rtl/fetch_mem_arbiter_pkg.sv
// Shared types for the IF/MEM external memory arbiter.
// FSM states, grant encoding and default access length.
package fetch_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_t;

    localparam int WAIT_CYCLES_DEF = 4;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/fetch_mem_arbiter_rr_grant2.sv
// Two-requester round-robin picker.
// On a tie the requester that was not granted last wins.
module rr_grant2
    import fetch_mem_arbiter_pkg::*;
(
    input  logic   req_if_i,
    input  logic   req_mem_i,
    input  grant_t last_i,
    output logic   valid_o,
    output grant_t gnt_o
);

    // Pick a single winner from the pending requests
    always_comb begin
        valid_o = req_if_i | req_mem_i;
        gnt_o   = GNT_IF;
        if (req_if_i && req_mem_i) begin
            gnt_o = (last_i == GNT_IF) ? GNT_MEM : GNT_IF;
        end else if (req_mem_i) begin
            gnt_o = GNT_MEM;
        end
    end

endmodule

// File: rtl/fetch_mem_arbiter.sv
// Arbiter sharing one single-port external memory between IF and MEM.
// Fixed-length access followed by a one-cycle ready pulse.
module fetch_mem_arbiter
    import fetch_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd_req,
    input  logic              mem_wr_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              ext_en,
    output logic              ext_we,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    input  logic [DATA_W-1:0] ext_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    grant_t            last_q, last_d;
    grant_t            gnt_q, gnt_d;
    logic              en_q, en_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_rdy_q, if_rdy_d;
    logic              mem_rdy_q, mem_rdy_d;

    logic   pick_valid;
    grant_t pick;

    rr_grant2 u_rr (
        .req_if_i  (if_req),
        .req_mem_i (mem_rd_req | mem_wr_req),
        .last_i    (last_q),
        .valid_o   (pick_valid),
        .gnt_o     (pick)
    );

    // Next-state and registered-output logic for the access sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        en_d        = en_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_rdy_d    = 1'b0;
        mem_rdy_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                    gnt_d   = pick;
                    last_d  = pick;
                    en_d    = 1'b1;
                    if (pick == GNT_MEM) begin
                        addr_d  = mem_addr;
                        wdata_d = mem_wdata;
                        we_d    = mem_wr_req;
                    end else begin
                        addr_d  = if_addr;
                        wdata_d = '0;
                        we_d    = 1'b0;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    if (gnt_q == GNT_MEM) begin
                        mem_rdy_d = 1'b1;
                        if (!we_q) begin
                            mem_rdata_d = ext_rdata;
                        end
                    end else begin
                        if_rdy_d   = 1'b1;
                        if_rdata_d = ext_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= GNT_IF;
            gnt_q       <= GNT_IF;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_rdy_q    <= 1'b0;
            mem_rdy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            en_q        <= en_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_rdy_q    <= if_rdy_d;
            mem_rdy_q   <= mem_rdy_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_rdy_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_ready = mem_rdy_q;
    assign ext_en    = en_q;
    assign ext_we    = we_q;
    assign ext_addr  = addr_q;
    assign ext_wdata = wdata_q;
    assign busy      = (state_q != IDLE);

endmodule
